// File: rtl/warp_xrf_wb_arbiter.sv
// Writeback arbiter for the scalar integer register file.
// Grants up to two producer writes per cycle in round-robin order and registers
// them onto the two xrf write ports. Writes to x0 are accepted and dropped.
module warp_xrf_wb_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_stall,
    input  logic [NUM_REQ-1:0]      i_req_valid,
    input  logic [5*NUM_REQ-1:0]    i_req_addr,
    input  logic [64*NUM_REQ-1:0]   i_req_data,
    output logic [NUM_REQ-1:0]      o_req_ready,
    output logic [4:0]              o_rd1_addr,
    output logic [63:0]             o_rd1_wdata,
    output logic                    o_rd1_wen,
    output logic [4:0]              o_rd2_addr,
    output logic [63:0]             o_rd2_wdata,
    output logic                    o_rd2_wen
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptr_nxt;
    logic [NUM_REQ-1:0] ready_raw;
    logic               a_found;
    logic               b_found;
    logic [4:0]         a_addr;
    logic [4:0]         b_addr;
    logic [63:0]        a_data;
    logic [63:0]        b_data;
    logic               block;
    logic               grant_a;
    logic               grant_b;

    assign block = i_rst | i_stall;

    // Rotating scan from ptr: pass 0 covers ptr..NUM_REQ-1, pass 1 wraps to 0..ptr-1.
    always_comb begin
        ready_raw = '0;
        a_found   = 1'b0;
        b_found   = 1'b0;
        a_addr    = '0;
        b_addr    = '0;
        a_data    = '0;
        b_data    = '0;
        ptr_nxt   = ptr;
        for (int pass = 0; pass < 2; pass++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if ((pass == 0 && j >= int'(ptr)) || (pass == 1 && j < int'(ptr))) begin
                    if (i_req_valid[j]) begin
                        if (i_req_addr[5*j +: 5] == 5'd0) begin
                            // x0 writes are accepted but use no port and leave ptr alone
                            ready_raw[j] = 1'b1;
                        end else if (!a_found) begin
                            a_found      = 1'b1;
                            a_addr       = i_req_addr[5*j +: 5];
                            a_data       = i_req_data[64*j +: 64];
                            ready_raw[j] = 1'b1;
                            ptr_nxt      = (j == NUM_REQ-1) ? '0 : PTR_W'(j + 1);
                        end else if (!b_found && (i_req_addr[5*j +: 5] != a_addr)) begin
                            // a second write to slot A's register must wait a cycle
                            b_found      = 1'b1;
                            b_addr       = i_req_addr[5*j +: 5];
                            b_data       = i_req_data[64*j +: 64];
                            ready_raw[j] = 1'b1;
                            ptr_nxt      = (j == NUM_REQ-1) ? '0 : PTR_W'(j + 1);
                        end
                    end
                end
            end
        end
    end

    assign o_req_ready = block ? '0 : ready_raw;
    assign grant_a     = a_found & ~block;
    assign grant_b     = b_found & ~block;

    // Register granted slots onto the write ports and advance the pointer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr         <= '0;
            o_rd1_addr  <= '0;
            o_rd1_wdata <= '0;
            o_rd1_wen   <= 1'b0;
            o_rd2_addr  <= '0;
            o_rd2_wdata <= '0;
            o_rd2_wen   <= 1'b0;
        end else begin
            o_rd1_wen <= grant_a;
            o_rd2_wen <= grant_b;
            if (grant_a) begin
                o_rd1_addr  <= a_addr;
                o_rd1_wdata <= a_data;
                ptr         <= ptr_nxt;
            end
            if (grant_b) begin
                o_rd2_addr  <= b_addr;
                o_rd2_wdata <= b_data;
            end
        end
    end

endmodule

// File: tb/tb_warp_xrf_wb_arbiter.sv
// Self-checking bench for warp_xrf_wb_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the arbiter.
module tb_warp_xrf_wb_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           stall;
    logic [N-1:0]   req_valid;
    logic [5*N-1:0] req_addr;
    logic [64*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [4:0]     rd1_addr, rd2_addr;
    logic [63:0]    rd1_wdata, rd2_wdata;
    logic           rd1_wen, rd2_wen;

    int n_chk  = 0;
    int n_pass = 0;

    // model state
    int          m_ptr   = 0;
    logic        m_wen1  = 0, m_wen2 = 0;
    logic [4:0]  m_addr1 = 0, m_addr2 = 0;
    logic [63:0] m_data1 = 0, m_data2 = 0;
    logic [N-1:0] m_rdy;
    int          m_qa, m_qb;
    logic [N-1:0] rdy_seen;

    warp_xrf_wb_arbiter #(.NUM_REQ(N)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_stall     (stall),
        .i_req_valid (req_valid),
        .i_req_addr  (req_addr),
        .i_req_data  (req_data),
        .o_req_ready (req_ready),
        .o_rd1_addr  (rd1_addr),
        .o_rd1_wdata (rd1_wdata),
        .o_rd1_wen   (rd1_wen),
        .o_rd2_addr  (rd2_addr),
        .o_rd2_wdata (rd2_wdata),
        .o_rd2_wen   (rd2_wen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic set_req(input int k, input logic v, input logic [4:0] a, input logic [63:0] d);
        req_valid[k]       = v;
        req_addr[5*k +: 5] = a;
        req_data[64*k +: 64] = d;
    endtask

    function automatic logic [4:0] addr_of(input int k);
        return req_addr[5*k +: 5];
    endfunction

    // Decide this cycle's grants from the rules: walk requesters in priority order
    // starting at the pointer; x0 is free, first real write is A, next different-reg write is B.
    task automatic model_eval();
        m_rdy = '0;
        m_qa  = -1;
        m_qb  = -1;
        if (!rst && !stall) begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = (m_ptr + i) % N;
                if (req_valid[k]) begin
                    if (addr_of(k) == 0) m_rdy[k] = 1'b1;
                    else if (m_qa < 0) begin m_qa = k; m_rdy[k] = 1'b1; end
                    else if (m_qb < 0 && addr_of(k) != addr_of(m_qa)) begin m_qb = k; m_rdy[k] = 1'b1; end
                end
            end
        end
    endtask

    task automatic model_apply(input logic [4:0] a_a, input logic [63:0] a_d,
                               input logic [4:0] b_a, input logic [63:0] b_d, input logic r);
        if (r) begin
            m_ptr = 0; m_wen1 = 0; m_wen2 = 0;
            m_addr1 = 0; m_addr2 = 0; m_data1 = 0; m_data2 = 0;
        end else if (m_qa >= 0) begin
            m_wen1 = 1; m_addr1 = a_a; m_data1 = a_d;
            if (m_qb >= 0) begin m_wen2 = 1; m_addr2 = b_a; m_data2 = b_d; end
            else m_wen2 = 0;
            m_ptr = (((m_qb >= 0) ? m_qb : m_qa) + 1) % N;
        end else begin
            m_wen1 = 0; m_wen2 = 0;
        end
    endtask

    // One clock: check combinational ready before the edge, registered outputs after it.
    task automatic cyc();
        logic [4:0]  a_a, b_a;
        logic [63:0] a_d, b_d;
        logic        r;
        #1;
        model_eval();
        rdy_seen = req_ready;
        chk("ready", {60'd0, req_ready}, {60'd0, m_rdy});
        a_a = (m_qa >= 0) ? addr_of(m_qa) : 5'd0;
        a_d = (m_qa >= 0) ? req_data[64*m_qa +: 64] : 64'd0;
        b_a = (m_qb >= 0) ? addr_of(m_qb) : 5'd0;
        b_d = (m_qb >= 0) ? req_data[64*m_qb +: 64] : 64'd0;
        r   = rst;
        @(posedge clk);
        model_apply(a_a, a_d, b_a, b_d, r);
        #1;
        chk("rd1_wen",   {63'd0, rd1_wen}, {63'd0, m_wen1});
        chk("rd2_wen",   {63'd0, rd2_wen}, {63'd0, m_wen2});
        chk("rd1_addr",  {59'd0, rd1_addr}, {59'd0, m_addr1});
        chk("rd2_addr",  {59'd0, rd2_addr}, {59'd0, m_addr2});
        chk("rd1_wdata", rd1_wdata, m_data1);
        chk("rd2_wdata", rd2_wdata, m_data2);
        chk("ptr", {62'd0, dut.ptr}, 64'(m_ptr));
        @(negedge clk);
    endtask

    initial begin
        rst = 1; stall = 0;
        req_valid = '0; req_addr = '0; req_data = '0;
        for (int k = 0; k < N; k++) set_req(k, 1, 5'(k + 1), 64'(k + 100));

        // reset held two cycles with everything valid
        cyc(); chk("rst_ready0", {60'd0, rdy_seen}, 64'd0);
        cyc(); chk("rst_ready1", {60'd0, rdy_seen}, 64'd0);
        chk("rst_wen1", {63'd0, rd1_wen}, 64'd0);
        chk("rst_wen2", {63'd0, rd2_wen}, 64'd0);
        chk("rst_ptr",  {62'd0, dut.ptr}, 64'd0);

        // two grants
        rst = 0; req_valid = '0;
        set_req(0, 1, 5'd5, 64'hA);
        set_req(2, 1, 5'd7, 64'hB);
        cyc();
        chk("two_ready", {60'd0, rdy_seen}, 64'b0101);
        chk("two_rd1", {rd1_wen, rd1_addr, rd1_wdata[7:0]}, {1'b1, 5'd5, 8'hA});
        chk("two_rd2", {rd2_wen, rd2_addr, rd2_wdata[7:0]}, {1'b1, 5'd7, 8'hB});
        chk("two_ptr", {62'd0, dut.ptr}, 64'd3);

        // round robin from ptr=0
        rst = 1; req_valid = '0; cyc();
        rst = 0;
        for (int k = 0; k < N; k++) set_req(k, 1, 5'(k + 10), 64'(k + 200));
        cyc(); chk("rr0", {60'd0, rdy_seen}, 64'b0011);
        cyc(); chk("rr1", {60'd0, rdy_seen}, 64'b1100);
        cyc(); chk("rr2", {60'd0, rdy_seen}, 64'b0011);
        cyc(); chk("rr3", {60'd0, rdy_seen}, 64'b1100);

        // same-address conflict
        req_valid = '0;
        set_req(1, 1, 5'd9, 64'h11);
        set_req(3, 1, 5'd9, 64'h33);
        cyc();
        chk("conf_ready", {60'd0, rdy_seen}, 64'b0010);
        chk("conf_wen2", {63'd0, rd2_wen}, 64'd0);
        chk("conf_ptr", {62'd0, dut.ptr}, 64'd2);
        req_valid[1] = 0;
        cyc();
        chk("conf_next", {60'd0, rdy_seen}, 64'b1000);
        chk("conf_rd1", {rd1_wen, rd1_addr, rd1_wdata[7:0]}, {1'b1, 5'd9, 8'h33});

        // x0 absorb
        req_valid = '0;
        set_req(0, 1, 5'd0, 64'hDEAD);
        set_req(1, 1, 5'd3, 64'h77);
        cyc();
        chk("x0_ready", {60'd0, rdy_seen}, 64'b0011);
        chk("x0_rd1", {rd1_wen, rd1_addr, rd1_wdata[7:0]}, {1'b1, 5'd3, 8'h77});
        chk("x0_wen2", {63'd0, rd2_wen}, 64'd0);
        chk("x0_ptr", {62'd0, dut.ptr}, 64'd2);

        // stall holds the pointer; grant resumes from it
        req_valid = '0;
        set_req(0, 1, 5'd4, 64'h44);
        set_req(3, 1, 5'd6, 64'h66);
        stall = 1;
        cyc();
        chk("stall_ready", {60'd0, rdy_seen}, 64'd0);
        chk("stall_wen", {62'd0, rd1_wen, rd2_wen}, 64'd0);
        chk("stall_ptr", {62'd0, dut.ptr}, 64'd2);
        stall = 0;
        cyc();
        chk("unstall_ready", {60'd0, rdy_seen}, 64'b1001);
        chk("unstall_rd1", {59'd0, rd1_addr}, 64'd6);
        chk("unstall_rd2", {59'd0, rd2_addr}, 64'd4);

        // randomized traffic: requesters hold until accepted
        req_valid = '0;
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!req_valid[k] && ($urandom_range(0, 1) == 1))
                    set_req(k, 1, 5'($urandom_range(0, 7)), {$urandom, $urandom});
            end
            stall = ($urandom_range(0, 7) == 0);
            rst   = ($urandom_range(0, 39) == 0);
            cyc();
            for (int k = 0; k < N; k++)
                if (rdy_seen[k]) req_valid[k] = 0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
